// File: rtl/main_memory_if.sv
`default_nettype none
// ============================================================================
// main_memory_if : request/response bus between an initiator and main_memory
// Revision       : 1.0
// ============================================================================
interface main_memory_if #(
   parameter int PHYSICAL_ADDRESS_SIZE = 56
);
   logic                             doFetch;
   logic                             doWrite;
   logic [PHYSICAL_ADDRESS_SIZE-1:0] address;
   logic [63:0]                      dataIn;
   logic [63:0]                      dataOut;
   logic                             done;
   logic                             busy;
   logic                             error;

   modport master (
      output doFetch, doWrite, address, dataIn,
      input  dataOut, done, busy, error
   );

   modport slave (
      input  doFetch, doWrite, address, dataIn,
      output dataOut, done, busy, error
   );
endinterface
`default_nettype wire

// File: rtl/main_memory.sv
`default_nettype none
// ============================================================================
// main_memory : fixed-latency 64-bit main-memory responder (one request at a
//               time). Define MAINMEM_RANGECHECK_EN to flag out-of-range use.
// Revision    : 1.0
// ============================================================================
module main_memory #(
   parameter int PHYSICAL_ADDRESS_SIZE = 56,
   parameter int MEMORY_WORDS          = 4096,
   parameter int READ_LATENCY          = 4,
   parameter int WRITE_LATENCY         = 2
) (
   input  wire logic    clk,
   input  wire logic    reset,
   main_memory_if.slave bus
);
   localparam int IDX_W     = $clog2(MEMORY_WORDS);
   localparam int UPPER_LSB = 3 + IDX_W;
   localparam int MAX_LAT   = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
   localparam int CNT_W     = ($clog2(MAX_LAT) < 1) ? 1 : $clog2(MAX_LAT);

   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_READ_WAIT  = 2'd1,
      S_WRITE_WAIT = 2'd2
   } state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [IDX_W-1:0]   idx_q;
   logic [63:0]        wdata_q;
   logic [63:0]        dout_q;
   logic               done_q;
   logic               busy_q;
   logic [63:0]        mem_q [MEMORY_WORDS];

   logic [IDX_W-1:0]   idx_d;
   logic               upper_nz_d;
   logic               oor;
   logic               mem_we;
   logic               unused_addr;

   assign idx_d = bus.address[3 +: IDX_W];

   generate
      if (PHYSICAL_ADDRESS_SIZE > UPPER_LSB) begin : g_upper
         assign upper_nz_d = |bus.address[PHYSICAL_ADDRESS_SIZE-1:UPPER_LSB];
      end else begin : g_no_upper
         assign upper_nz_d = 1'b0;
      end
   endgenerate

`ifdef MAINMEM_RANGECHECK_EN
   logic oor_q;
   logic error_q;

   assign oor         = oor_q;
   assign bus.error   = error_q;
   assign unused_addr = ^bus.address[2:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         oor_q   <= 1'b0;
         error_q <= 1'b0;
      end else begin
         error_q <= 1'b0;
         if (state_q == S_IDLE && (bus.doWrite || bus.doFetch)) begin
            oor_q <= upper_nz_d;
         end
         if (state_q != S_IDLE && cnt_q == '0) begin
            error_q <= oor_q;
         end
      end
   end
`else
   // Upper address bits alias onto the index field; nothing is ever flagged.
   assign oor         = 1'b0;
   assign bus.error   = 1'b0;
   assign unused_addr = ^{upper_nz_d, bus.address[2:0]};
`endif

   assign bus.dataOut = dout_q;
   assign bus.done    = done_q;
   assign bus.busy    = busy_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
         dout_q  <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               // A simultaneous read is dropped: the write takes priority.
               if (bus.doWrite) begin
                  idx_q   <= idx_d;
                  wdata_q <= bus.dataIn;
                  cnt_q   <= CNT_W'(WRITE_LATENCY - 1);
                  busy_q  <= 1'b1;
                  state_q <= S_WRITE_WAIT;
               end else if (bus.doFetch) begin
                  idx_q   <= idx_d;
                  cnt_q   <= CNT_W'(READ_LATENCY - 1);
                  busy_q  <= 1'b1;
                  state_q <= S_READ_WAIT;
               end
            end
            S_READ_WAIT: begin
               if (cnt_q == '0) begin
                  dout_q  <= oor ? 64'd0 : mem_q[idx_q];
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_WRITE_WAIT: begin
               if (cnt_q == '0) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Storage has no reset; a reset on the completion edge cancels the write.
   assign mem_we = !reset && (state_q == S_WRITE_WAIT) && (cnt_q == '0) && !oor;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[idx_q] <= wdata_q;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_main_memory.sv
`default_nettype none
// ============================================================================
// tb_main_memory : directed scoreboard bench for main_memory
// Revision       : 1.0
// ============================================================================
module tb_main_memory;
   localparam int PAS = 56;
   localparam int RL  = 4;
   localparam int WL  = 2;

   typedef struct packed {
      logic [63:0] data;
      logic        err;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   exp_t sb [$];
   logic [63:0] exp_dout = 64'd0;

`ifdef MAINMEM_RANGECHECK_EN
   localparam logic RC = 1'b1;
`else
   localparam logic RC = 1'b0;
`endif

   main_memory_if #(.PHYSICAL_ADDRESS_SIZE(PAS)) bus ();

   main_memory #(
      .PHYSICAL_ADDRESS_SIZE(PAS),
      .MEMORY_WORDS         (4096),
      .READ_LATENCY         (RL),
      .WRITE_LATENCY        (WL)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Completion monitor: every done pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (!reset && bus.done === 1'b1) begin
         exp_t e;
         checks++;
         assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL spurious_done observed=done expected=no_done");
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("done_data", bus.dataOut, e.data);
            check("done_error", {63'd0, bus.error}, {63'd0, e.err});
         end
      end
   end

   // Called just after a rising edge; returns just after the done edge.
   task automatic do_req(input logic wr, input logic rd, input logic [PAS-1:0] a,
                         input logic [63:0] d, input int lat, input logic exp_err,
                         input logic [63:0] exp_rd);
      bus.doWrite = wr;
      bus.doFetch = rd;
      bus.address = a;
      bus.dataIn  = d;
      if (!wr) exp_dout = exp_rd;
      sb.push_back('{data: exp_dout, err: exp_err});
      @(posedge clk); #1;
      bus.doWrite = 1'b0;
      bus.doFetch = 1'b0;
      check("busy_after_sample", {63'd0, bus.busy}, 64'd1);
      for (int k = 1; k <= lat; k++) begin
         @(posedge clk); #1;
         check($sformatf("done_at_%0d", k), {63'd0, bus.done}, {63'd0, (k == lat)});
         check($sformatf("busy_at_%0d", k), {63'd0, bus.busy}, {63'd0, (k < lat)});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      bus.doFetch = 1'b0;
      bus.doWrite = 1'b0;
      bus.address = '0;
      bus.dataIn  = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("rst_done",    {63'd0, bus.done},  64'd0);
      check("rst_busy",    {63'd0, bus.busy},  64'd0);
      check("rst_error",   {63'd0, bus.error}, 64'd0);
      check("rst_dataOut", bus.dataOut,        64'd0);

      do_req(1, 0, 56'h0, 64'd0, WL, 1'b0, 64'd0);
      do_req(1, 0, 56'h40, 64'hDEADBEEF_CAFEF00D, WL, 1'b0, 64'd0);
      do_req(0, 1, 56'h40, 64'd0, RL, 1'b0, 64'hDEADBEEF_CAFEF00D);
      do_req(0, 1, 56'h47, 64'd0, RL, 1'b0, 64'hDEADBEEF_CAFEF00D);

      // Both strobes high: the write must win, completing at write latency.
      do_req(1, 1, 56'h80, 64'h1, WL, 1'b0, 64'd0);
      do_req(0, 1, 56'h80, 64'd0, RL, 1'b0, 64'h1);

      // Requests while busy are ignored.
      bus.doFetch = 1'b1;
      bus.address = 56'h40;
      exp_dout = 64'hDEADBEEF_CAFEF00D;
      sb.push_back('{data: exp_dout, err: 1'b0});
      @(posedge clk); #1;
      bus.address = 56'h80;
      check("busy_hold_n", {63'd0, bus.busy}, 64'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.doFetch = 1'b0;
      @(posedge clk); #1;
      check("busy_done_n3", {63'd0, bus.done}, 64'd0);
      @(posedge clk); #1;
      check("busy_done_n4", {63'd0, bus.done}, 64'd1);
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         check("busy_no_extra", {63'd0, bus.done}, 64'd0);
      end

      // Reset on the completion edge of a write cancels it.
      do_req(1, 0, 56'h100, 64'hAAAA5555_00001111, WL, 1'b0, 64'd0);
      bus.doWrite = 1'b1;
      bus.address = 56'h100;
      bus.dataIn  = 64'h55;
      @(posedge clk); #1;
      bus.doWrite = 1'b0;
      check("rstmid_busy", {63'd0, bus.busy}, 64'd1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_dout = 64'd0;
      check("rstmid_done",    {63'd0, bus.done}, 64'd0);
      check("rstmid_busy0",   {63'd0, bus.busy}, 64'd0);
      check("rstmid_dataOut", bus.dataOut,       64'd0);
      @(posedge clk); #1;
      check("rstmid_done2", {63'd0, bus.done}, 64'd0);
      do_req(0, 1, 56'h100, 64'd0, RL, 1'b0, 64'hAAAA5555_00001111);

      // Beyond the 4096-word space.
      do_req(1, 0, 56'h8000, 64'h77, WL, RC, 64'd0);
      if (RC) begin
         do_req(0, 1, 56'h8000, 64'd0, RL, 1'b1, 64'd0);
         do_req(0, 1, 56'h0,    64'd0, RL, 1'b0, 64'd0);
      end else begin
         do_req(0, 1, 56'h0,    64'd0, RL, 1'b0, 64'h77);
      end

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/main_memory.md
# main_memory

Main-memory responder on the physical bus, at the far end of the L2 cache's main-memory port. It accepts single 64-bit read and write requests, holds each for a fixed parameterised latency, then completes it with a one-cycle `done` pulse. Read data is returned on `dataOut`. It is the system-side endpoint used in simulation and on FPGA builds.

## Interface
- `PHYSICAL_ADDRESS_SIZE`, 56: width of `address`.
- `MEMORY_WORDS`, 4096: number of 64-bit words; power of two, ≥2.
- `READ_LATENCY`, 4: cycles from request sample to read `done`; ≥1.
- `WRITE_LATENCY`, 2: cycles from request sample to write `done`; ≥1.
- `clk` in 1: single clock; everything on posedge.
- `reset` in 1: synchronous, active-high.
- `doFetch` in 1: read request.
- `doWrite` in 1: write request.
- `address` in `PHYSICAL_ADDRESS_SIZE`: byte address; bits [2:0] ignored (word aligned).
- `dataIn` in 64: write data.
- `dataOut` out 64: read data; valid while `done`=1, held until the next read completes.
- `done` out 1: one-cycle completion pulse.
- `busy` out 1: request in flight; new requests are ignored while high.
- `error` out 1: out-of-range access flag, asserted with `done` (see Configuration).

## Operation
- States: IDLE, READ_WAIT, WRITE_WAIT.
- IDLE:
  - `doWrite`=1 → latch address and data, load counter with `WRITE_LATENCY`-1, go to WRITE_WAIT.
  - Else `doFetch`=1 → latch address, load counter with `READ_LATENCY`-1, go to READ_WAIT.
  - Both high → write wins; the read is dropped.
- Requests are sampled only in IDLE. A request present while `busy`=1 is ignored, not queued. The initiator must re-issue or hold it.
- READ_WAIT / WRITE_WAIT: decrement the counter each cycle. At counter 0, complete and return to IDLE.
- Read completion: `dataOut` ← mem[index] read at the completion edge; `done`=1.
- Write completion: mem[index] ← latched data at the completion edge; `done`=1; `dataOut` unchanged.
- Index = `address`[3 +: log2(`MEMORY_WORDS`)]. Upper bits are handled per Configuration.
- Reset:
  - `done`=0, `busy`=0, `error`=0, `dataOut`=0, state IDLE.
  - A pending write is dropped.
  - Memory contents are not cleared.
- Reset mid-operation: the in-flight request is abandoned with no `done`. IDLE is reached on the next edge.

## Timing
- Request sampled at edge N.
- `busy` rises at N and falls at N+LAT.
- `done` rises at N+LAT and falls at N+LAT+1 (LAT = `READ_LATENCY` or `WRITE_LATENCY`).
- The next request can be sampled at edge N+LAT+1, since `busy`=0 during the `done` cycle. Back-to-back period is LAT+1 cycles.
- LAT=1 is legal: `done` comes the cycle after the sample.
- A read issued after a write's `done` returns the written data. Ordering is strict; there is no bypass or overlap.
- `done` is never high for two consecutive cycles.

## Configuration
- `MAINMEM_RANGECHECK_EN` defined:
  - Any nonzero address bit above the index field marks the access out of range.
  - On completion, `error`=1 together with `done`.
  - Reads return `dataOut`=0; writes leave memory unchanged.
  - Timing is identical to an in-range access.
- Not defined:
  - Upper bits are ignored and addresses alias modulo `MEMORY_WORDS`×8 bytes.
  - `error` is tied to 0.

## Test plan
- Reset, then idle 5 cycles → `done`=0, `busy`=0, `error`=0, `dataOut`=0.
- Write 0xDEADBEEF_CAFEF00D to 0x40 (sample edge N) → `done` at N+2 only. Then read 0x40 → `done` at N+3+4 with `dataOut`=0xDEADBEEF_CAFEF00D. Read 0x47 → same data.
- `doFetch` and `doWrite` both high at 0x80 with data 0x1 → one `done` at N+2 (write). A following read of 0x80 returns 0x1.
- Pulse `doFetch` at N+1 and N+2 while `busy` → ignored; exactly one `done`.
- Assert `reset` at N+2 during a write to 0x100 with data 0x55 → no `done`. A later read of 0x100 returns the prior contents.
- Write 0x77 to 0x8000 (beyond 4096 words):
  - With `MAINMEM_RANGECHECK_EN`: `error`=1 with `done`; reads of 0x8000 and of 0x0 both return 0.
  - Without it: the write aliases, and reading 0x0 returns 0x77 with `error`=0.
